// File: rtl/alu_seq.sv
// alu_seq: ALU with single-cycle ops plus iterative shift-add multiply and restoring divide.
// Define ALU_SEQ_DIV_EN to build the divider; without it Op=10 behaves as the reserved Op=11.
module alu_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [5:0]       ALUFun,
   input  logic             Sign,
   input  logic [1:0]       Op,
   output logic             out_valid,
   output logic [WIDTH-1:0] OUT,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic             div_zero
);

   localparam int SHW = $clog2(WIDTH);

   typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

   state_e             state_q, state_d;
   logic [SHW-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]   acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, m_q, m_d;
   logic               neg_q, neg_d;
   logic               out_valid_q, out_valid_d;
   logic [WIDTH-1:0]   out_q, out_d, hi_q, hi_d, lo_q, lo_d;
   logic               accept;
   logic [WIDTH-1:0]   alu_res, abs_a, abs_b;
   logic [SHW-1:0]     shamt;
   logic [WIDTH:0]     mul_add;
   logic [WIDTH-1:0]   mul_hi_n, mul_lo_n;
   logic [2*WIDTH-1:0] prod, prod_fix;
`ifdef ALU_SEQ_DIV_EN
   logic               negr_q, negr_d;
   logic               dz_q, dz_d;
   logic [WIDTH:0]     div_sh, div_diff;
   logic               div_ok;
   logic [WIDTH-1:0]   rem_n, quo_n;
`endif

   assign in_ready  = (state_q == StIdle) || (state_q == StDone);
   assign accept    = in_valid & in_ready;
   assign out_valid = out_valid_q;
   assign OUT       = out_q;
   assign HI        = hi_q;
   assign LO        = lo_q;
`ifdef ALU_SEQ_DIV_EN
   assign div_zero  = dz_q;
`else
   assign div_zero  = 1'b0;
`endif

   assign shamt = A[SHW-1:0];
   assign abs_a = (Sign && A[WIDTH-1]) ? -A : A;
   assign abs_b = (Sign && B[WIDTH-1]) ? -B : B;

   always_comb begin
      alu_res = A;
      case (ALUFun[5:4])
         2'b00: alu_res = ALUFun[0] ? (A - B) : (A + B);
         2'b01: begin
            case (ALUFun[3:0])
               4'b1000: alu_res = A & B;
               4'b1110: alu_res = A | B;
               4'b0110: alu_res = A ^ B;
               4'b0001: alu_res = ~(A | B);
               default: alu_res = A;
            endcase
         end
         2'b10: begin
            case (ALUFun[1:0])
               2'b01:   alu_res = B >> shamt;
               2'b11:   alu_res = $unsigned($signed(B) >>> shamt);
               default: alu_res = B << shamt;
            endcase
         end
         default: begin
            alu_res = '0;
            case (ALUFun)
               6'b110011: alu_res[0] = (A == B);
               6'b110001: alu_res[0] = (A != B);
               6'b110101: alu_res[0] = Sign ? ($signed(A) < $signed(B)) : (A < B);
               6'b111101: alu_res[0] = A[WIDTH-1] | (A == '0);
               6'b111011: alu_res[0] = A[WIDTH-1];
               6'b111111: alu_res[0] = ~A[WIDTH-1] & (A != '0);
               default:   alu_res[0] = 1'b0;
            endcase
         end
      endcase
   end

   // One shift-add step: {carry, hi, lo} >> 1 after conditionally adding the multiplicand.
   assign mul_add  = acc_lo_q[0] ? ({1'b0, acc_hi_q} + {1'b0, m_q}) : {1'b0, acc_hi_q};
   assign mul_hi_n = mul_add[WIDTH:1];
   assign mul_lo_n = {mul_add[0], acc_lo_q[WIDTH-1:1]};
   assign prod     = {mul_hi_n, mul_lo_n};
   assign prod_fix = neg_q ? -prod : prod;

`ifdef ALU_SEQ_DIV_EN
   assign div_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
   assign div_diff = div_sh - {1'b0, m_q};
   assign div_ok   = ~div_diff[WIDTH];
   assign rem_n    = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
   assign quo_n    = {acc_lo_q[WIDTH-2:0], div_ok};
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_hi_d    = acc_hi_q;
      acc_lo_d    = acc_lo_q;
      m_d         = m_q;
      neg_d       = neg_q;
      out_valid_d = 1'b0;
      out_d       = out_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
`ifdef ALU_SEQ_DIV_EN
      negr_d      = negr_q;
      dz_d        = 1'b0;
`endif
      case (state_q)
         StIdle, StDone: begin
            state_d = StIdle;
            if (accept) begin
               case (Op)
                  2'b00: begin
                     out_d       = alu_res;
                     out_valid_d = 1'b1;
                  end
                  2'b01: begin
                     acc_hi_d = '0;
                     acc_lo_d = abs_b;
                     m_d      = abs_a;
                     neg_d    = Sign & (A[WIDTH-1] ^ B[WIDTH-1]);
                     cnt_d    = SHW'(WIDTH - 1);
                     state_d  = StMul;
                  end
`ifdef ALU_SEQ_DIV_EN
                  2'b10: begin
                     // Raw A is kept when B=0 so the divide-by-zero path can return it in HI.
                     acc_hi_d = '0;
                     acc_lo_d = (B == '0) ? A : abs_a;
                     m_d      = abs_b;
                     neg_d    = Sign & (A[WIDTH-1] ^ B[WIDTH-1]);
                     negr_d   = Sign & A[WIDTH-1];
                     cnt_d    = SHW'(WIDTH - 1);
                     state_d  = StDiv;
                  end
`endif
                  default: begin
                     out_d       = '0;
                     out_valid_d = 1'b1;
                  end
               endcase
            end
         end
         StMul: begin
            acc_hi_d = mul_hi_n;
            acc_lo_d = mul_lo_n;
            cnt_d    = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               state_d     = StDone;
               out_valid_d = 1'b1;
               hi_d        = prod_fix[2*WIDTH-1:WIDTH];
               lo_d        = prod_fix[WIDTH-1:0];
               out_d       = prod_fix[WIDTH-1:0];
            end
         end
`ifdef ALU_SEQ_DIV_EN
         StDiv: begin
            if (m_q == '0) begin
               state_d     = StDone;
               out_valid_d = 1'b1;
               dz_d        = 1'b1;
               hi_d        = acc_lo_q;
               lo_d        = '1;
               out_d       = '1;
            end else begin
               acc_hi_d = rem_n;
               acc_lo_d = quo_n;
               cnt_d    = cnt_q - 1'b1;
               if (cnt_q == '0) begin
                  state_d     = StDone;
                  out_valid_d = 1'b1;
                  hi_d        = negr_q ? -rem_n : rem_n;
                  lo_d        = neg_q ? -quo_n : quo_n;
                  out_d       = neg_q ? -quo_n : quo_n;
               end
            end
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         acc_hi_q    <= '0;
         acc_lo_q    <= '0;
         m_q         <= '0;
         neg_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_q       <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
`ifdef ALU_SEQ_DIV_EN
         negr_q      <= 1'b0;
         dz_q        <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_hi_q    <= acc_hi_d;
         acc_lo_q    <= acc_lo_d;
         m_q         <= m_d;
         neg_q       <= neg_d;
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
`ifdef ALU_SEQ_DIV_EN
         negr_q      <= negr_d;
         dz_q        <= dz_d;
`endif
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=32.
module tb_alu_seq;
   localparam int W = 32;

   logic         clk, reset, in_valid, in_ready, Sign, out_valid, div_zero;
   logic [W-1:0] A, B, OUT, HI, LO;
   logic [5:0]   ALUFun;
   logic [1:0]   Op;
   int           checks = 0;
   int           failures = 0;
   int           lat, lowcnt, ovcnt;

   alu_seq #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .ALUFun(ALUFun), .Sign(Sign), .Op(Op),
      .out_valid(out_valid), .OUT(OUT), .HI(HI), .LO(LO), .div_zero(div_zero)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge: present a request that is accepted at the next posedge.
   task automatic drive(input logic [1:0] op, input logic [5:0] fun, input logic sg,
                        input logic [W-1:0] a, input logic [W-1:0] b);
      in_valid = 1'b1;
      Op       = op;
      ALUFun   = fun;
      Sign     = sg;
      A        = a;
      B        = b;
   endtask

   // Scrambles inputs after acceptance and waits (bounded) for out_valid.
   task automatic wait_out();
      @(negedge clk);
      in_valid = 1'b0;
      A        = $urandom;
      B        = $urandom;
      Sign     = ~Sign;
      ALUFun   = 6'($urandom);
      lat      = 1;
      lowcnt   = 0;
      forever begin
         if (!in_ready) lowcnt++;
         if (out_valid || lat >= 100) break;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run(input string tag, input logic [1:0] op, input logic [5:0] fun,
                      input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] exp_out, input int exp_lat);
      drive(op, fun, sg, a, b);
      wait_out();
      check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      check({tag, "_out"}, 64'(OUT), 64'(exp_out));
   endtask

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      A        = '0;
      B        = '0;
      ALUFun   = '0;
      Sign     = 1'b0;
      Op       = '0;
      #2 reset = 1'b0;
      #1;
      check("rst_ov", 64'(out_valid), 64'd0);
      check("rst_out", 64'(OUT), 64'd0);
      check("rst_hi", 64'(HI), 64'd0);
      check("rst_lo", 64'(LO), 64'd0);
      check("rst_dz", 64'(div_zero), 64'd0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rst_rdy", 64'(in_ready), 64'd1);

      // Single-cycle ALU operations
      run("add_ovf", 2'b00, 6'b000000, 1'b0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1);
      run("sub",     2'b00, 6'b000001, 1'b0, 32'd5, 32'd7, 32'hFFFF_FFFE, 1);
      run("and",     2'b00, 6'b011000, 1'b0, 32'hF0F0_1234, 32'hFF00_FF00, 32'hF000_1200, 1);
      run("or",      2'b00, 6'b011110, 1'b0, 32'hF0F0_1234, 32'hFF00_FF00, 32'hFFF0_FF34, 1);
      run("xor",     2'b00, 6'b010110, 1'b0, 32'hF0F0_1234, 32'hFF00_FF00, 32'h0FF0_ED34, 1);
      run("nor",     2'b00, 6'b010001, 1'b0, 32'hF0F0_1234, 32'hFF00_FF00, 32'h000F_00CB, 1);
      run("logic_a", 2'b00, 6'b010000, 1'b0, 32'hF0F0_1234, 32'hFF00_FF00, 32'hF0F0_1234, 1);
      run("sll",     2'b00, 6'b100000, 1'b0, 32'd4, 32'h3, 32'h30, 1);
      run("sll_amt", 2'b00, 6'b100000, 1'b0, 32'h24, 32'h1, 32'h10, 1);
      run("sll_10",  2'b00, 6'b100010, 1'b0, 32'd1, 32'h1, 32'h2, 1);
      run("srl",     2'b00, 6'b100001, 1'b0, 32'd4, 32'h8000_0000, 32'h0800_0000, 1);
      run("sra_neg", 2'b00, 6'b100011, 1'b0, 32'd4, 32'h8000_0000, 32'hF800_0000, 1);
      run("sra_pos", 2'b00, 6'b100011, 1'b0, 32'd4, 32'h4000_0000, 32'h0400_0000, 1);
      run("lt_s",    2'b00, 6'b110101, 1'b1, 32'hFFFF_FFFF, 32'h1, 32'h1, 1);
      run("lt_u",    2'b00, 6'b110101, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1);
      run("eq",      2'b00, 6'b110011, 1'b0, 32'd5, 32'd5, 32'h1, 1);
      run("neq",     2'b00, 6'b110001, 1'b0, 32'd5, 32'd5, 32'h0, 1);
      run("lez",     2'b00, 6'b111101, 1'b0, 32'd0, 32'd9, 32'h1, 1);
      run("ltz",     2'b00, 6'b111011, 1'b0, 32'h8000_0000, 32'd0, 32'h1, 1);
      run("gtz_neg", 2'b00, 6'b111111, 1'b0, 32'h8000_0000, 32'd0, 32'h0, 1);
      run("gtz_pos", 2'b00, 6'b111111, 1'b0, 32'd1, 32'd0, 32'h1, 1);
      run("cmp_bad", 2'b00, 6'b110000, 1'b0, 32'd5, 32'd5, 32'h0, 1);
      check("alu_hi", 64'(HI), 64'd0);

      // Back-to-back acceptance
      drive(2'b00, 6'b000000, 1'b0, 32'd1, 32'd2);
      @(negedge clk);
      drive(2'b00, 6'b000001, 1'b0, 32'd10, 32'd4);
      check("b2b1_ov", 64'(out_valid), 64'd1);
      check("b2b1_out", 64'(OUT), 64'd3);
      @(negedge clk);
      in_valid = 1'b0;
      check("b2b2_ov", 64'(out_valid), 64'd1);
      check("b2b2_out", 64'(OUT), 64'd6);
      @(negedge clk);
      check("b2b_idle_ov", 64'(out_valid), 64'd0);

      // Multiply
      run("mul_s", 2'b01, 6'b0, 1'b1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 33);
      check("mul_s_rdylow", 64'(lowcnt), 64'd32);
      check("mul_s_hi", 64'(HI), 64'hFFFF_FFFF);
      check("mul_s_lo", 64'(LO), 64'hFFFF_FFEB);
      check("done_rdy", 64'(in_ready), 64'd1);
      run("in_done", 2'b00, 6'b000000, 1'b0, 32'd8, 32'd9, 32'd17, 1);
      check("alu_keep_hi", 64'(HI), 64'hFFFF_FFFF);
      check("alu_keep_lo", 64'(LO), 64'hFFFF_FFEB);
      run("mul_u", 2'b01, 6'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 33);
      check("mul_u_hi", 64'(HI), 64'hFFFF_FFFE);
      run("mul_min", 2'b01, 6'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0, 33);
      check("mul_min_hi", 64'(HI), 64'h4000_0000);
      check("mul_min_lo", 64'(LO), 64'h0);

      // Reserved op
      run("rsvd", 2'b11, 6'b0, 1'b0, 32'd3, 32'd4, 32'h0, 1);
      check("rsvd_hi", 64'(HI), 64'h4000_0000);

`ifdef ALU_SEQ_DIV_EN
      run("div_s", 2'b10, 6'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
      check("div_s_lo", 64'(LO), 64'hFFFF_FFFD);
      check("div_s_hi", 64'(HI), 64'hFFFF_FFFF);
      check("div_s_dz", 64'(div_zero), 64'd0);
      run("div_z", 2'b10, 6'b0, 1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 2);
      check("div_z_dz", 64'(div_zero), 64'd1);
      check("div_z_lo", 64'(LO), 64'hFFFF_FFFF);
      check("div_z_hi", 64'(HI), 64'hFFFF_FFF9);
      run("after_dz", 2'b00, 6'b000000, 1'b0, 32'd1, 32'd1, 32'd2, 1);
      check("after_dz_dz", 64'(div_zero), 64'd0);
`else
      run("div_off", 2'b10, 6'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'h0, 1);
      check("div_off_dz", 64'(div_zero), 64'd0);
      check("div_off_hi", 64'(HI), 64'h4000_0000);
      check("div_off_rdylow", 64'(lowcnt), 64'd0);
`endif

      // Reset in the middle of a multiply
      drive(2'b01, 6'b0, 1'b0, 32'd123, 32'd456);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      check("mid_busy", 64'(in_ready), 64'd0);
      reset = 1'b0;
      #1;
      check("mid_rst_ov", 64'(out_valid), 64'd0);
      check("mid_rst_hi", 64'(HI), 64'd0);
      check("mid_rst_lo", 64'(LO), 64'd0);
      check("mid_rst_out", 64'(OUT), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rel_rdy", 64'(in_ready), 64'd1);
      ovcnt = 0;
      repeat (40) begin
         if (out_valid) ovcnt++;
         @(negedge clk);
      end
      check("mid_no_ov", 64'(ovcnt), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; legal values 8, 16, 32, 64.
REQ-002 SHALL have derived localparam SHW, value log2(WIDTH), shift-amount width.
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  in  1  operation request.
REQ-006 SHALL have port in_ready  out  1  operation accepted when in_valid and in_ready are both high at a rising edge.
REQ-007 SHALL have ports A, B  in  WIDTH  operands.
REQ-008 SHALL have port ALUFun  in  6  single-cycle function select.
REQ-009 SHALL have port Sign  in  1  1 = signed, 0 = unsigned.
REQ-010 SHALL have port Op  in  2  operation class: 00 ALU, 01 MULT, 10 DIV, 11 reserved.
REQ-011 SHALL have port out_valid  out  1  one-cycle pulse marking valid OUT/HI/LO.
REQ-012 SHALL have port OUT  out  WIDTH  result.
REQ-013 SHALL have ports HI, LO  out  WIDTH  multiply/divide result registers.
REQ-014 SHALL have port div_zero  out  1  set with out_valid when a divide had B = 0.

Function
REQ-015 SHALL use FSM states IDLE, MUL, DIV, DONE; in_ready SHALL be high in IDLE and DONE only.
REQ-016 Op=00 accepted SHALL register OUT and pulse out_valid in the next cycle; back-to-back acceptance every cycle SHALL be supported.
REQ-017 ALUFun[5:4]=00: OUT = A+B, or A-B when ALUFun[0]=1, modulo 2^WIDTH.
REQ-018 ALUFun[5:4]=01: 1000 AND, 1110 OR, 0110 XOR, 0001 NOR, any other code OUT = A.
REQ-019 ALUFun[5:4]=10: B shifted by A[SHW-1:0]; ALUFun[1:0] 00 SLL, 01 SRL, 11 SRA filling with B[WIDTH-1]; 10 behaves as SLL.
REQ-020 ALUFun[5:4]=11: OUT = zero-extended 1-bit flag; 110011 EQ, 110001 NEQ, 110101 A<B (Sign selects signed/unsigned), 111101 A<=0, 111011 A<0, 111111 A>0; the A<=0/A<0/A>0 tests are signed; any other code gives 0.
REQ-021 Op=01 accepted SHALL enter MUL for exactly WIDTH cycles of shift-add, then DONE for one cycle asserting out_valid; {HI,LO} = 2*WIDTH-bit product, signed when Sign=1; OUT = LO.
REQ-022 Op=10 with B!=0 SHALL enter DIV for exactly WIDTH cycles of restoring division, then DONE; LO = quotient truncated toward zero, HI = remainder with the sign of A when Sign=1; OUT = LO; div_zero = 0.
REQ-023 Op=10 with B=0 SHALL go directly to DONE; LO = all ones, HI = A, OUT = all ones, div_zero = 1.
REQ-024 Signed MUL/DIV SHALL operate on magnitudes and negate results at the end; most-negative operands SHALL produce wrapped two's-complement results without a hang.
REQ-025 Operands SHALL be latched at acceptance; input changes during MUL/DIV SHALL have no effect.
REQ-026 A new operation accepted in DONE SHALL be processed normally while out_valid pulses for the finishing one.
REQ-027 Op=11 accepted SHALL pulse out_valid next cycle with OUT = 0; HI/LO unchanged.
REQ-028 HI/LO SHALL change only at the transition into DONE; ALU ops leave them unchanged.
REQ-029 div_zero SHALL be 0 whenever out_valid is 0.

Reset
REQ-030 reset low SHALL immediately force IDLE, out_valid=0, OUT=0, HI=0, LO=0, div_zero=0, aborting any operation in progress; in_ready SHALL be 1 in the first cycle after release.

Configuration
REQ-031 Macro ALU_SEQ_DIV_EN defined: divider and DIV state built per REQ-022/023.
REQ-032 ALU_SEQ_DIV_EN undefined: no divider logic; Op=10 SHALL behave exactly as Op=11 and div_zero SHALL be tied to 0.

Verification (WIDTH=32)
REQ-033 Op=00, ALUFun=000000, A=0x7FFFFFFF, B=1 -> OUT=0x80000000, out_valid one cycle after acceptance.
REQ-034 Op=00, ALUFun=100011, A=4, B=0x80000000 -> OUT=0xF8000000; B=0x40000000 -> OUT=0x04000000.
REQ-035 Op=00, ALUFun=110101, A=0xFFFFFFFF, B=1: Sign=1 -> OUT=1; Sign=0 -> OUT=0.
REQ-036 Op=01, Sign=1, A=0xFFFFFFFD, B=7 -> in_ready low 32 cycles, out_valid 33 cycles after acceptance, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-037 Op=10, Sign=1, A=0xFFFFFFF9, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; B=0 -> out_valid 2 cycles after acceptance, div_zero=1, LO=0xFFFFFFFF, HI=0xFFFFFFF9.
REQ-038 reset asserted 10 cycles into a MULT -> no out_valid, HI=LO=0, in_ready=1 in the first cycle after release.
